// File: rtl/game_ui_pkg.sv
// Shared constants and state encoding for the game-UI script sequencer and ROM reader.
package game_ui_pkg;

  localparam int GUI_ADDR_WIDTH     = 10;
  localparam int GUI_MAXIMUM_TIMES  = 30;
  localparam int GUI_TIMEOUT_CYCLES = 64;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQUEST = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_REQUEST = S_REQUEST,
    ST_ACK     = S_ACK,
    ST_HOLD    = S_HOLD,
    ST_DONE    = S_DONE
  } ui_state_e;

endpackage

// File: rtl/game_ui_sequencer_time.sv
// Saturating game-time counter: clears on script start, counts ticks while enabled.
module game_time_counter
  import game_ui_pkg::*;
#(
  parameter int WIDTH = GUI_MAXIMUM_TIMES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      r_count <= '0;
    else if (i_clear)
      r_count <= '0;
    else if (i_enable && i_tick && (r_count != {WIDTH{1'b1}}))
      r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/game_ui_sequencer.sv
// Steps the UI ROM reader through a script: request/ack handshake per entry,
// then holds each entry until game time reaches the expiry the reader returned.
module game_ui_sequencer
  import game_ui_pkg::*;
#(
  parameter int ADDR_WIDTH     = GUI_ADDR_WIDTH,
  parameter int MAXIMUM_TIMES  = GUI_MAXIMUM_TIMES,
  parameter int TIMEOUT_CYCLES = GUI_TIMEOUT_CYCLES
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_pause,
  input  logic                     i_time_tick,
  input  logic [ADDR_WIDTH-1:0]    i_start_addr,
  input  logic [ADDR_WIDTH-1:0]    i_end_addr,
  input  logic                     i_update_ui_time,
  input  logic [MAXIMUM_TIMES-1:0] i_next_ui_time,
  output logic [ADDR_WIDTH-1:0]    o_ui_addr,
  output logic                     o_sync_ui_time,
  output logic [MAXIMUM_TIMES-1:0] o_current_time,
  output logic                     o_ui_apply,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int             TCW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);

  ui_state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]    r_ui_addr;
  logic [MAXIMUM_TIMES-1:0] r_expiry;
  logic [TCW-1:0]           r_tcnt;
  logic                     r_sync, r_apply, r_busy, r_done, r_error;
  logic                     w_load, w_adv, w_latch, w_timeout, w_cnt_en;
  logic [MAXIMUM_TIMES-1:0] w_time;

  // Time only advances while a script runs and nobody is pausing it.
  assign w_cnt_en = r_busy & ~i_pause;

  game_time_counter #(.WIDTH(MAXIMUM_TIMES)) u_time (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_load),
    .i_enable (w_cnt_en),
    .i_tick   (i_time_tick),
    .o_count  (w_time)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and per-transition actions; an update beats a same-cycle timeout,
  // and the expiry compare sees the pre-tick time.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_latch     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_REQUEST;
          w_load      = 1'b1;
        end
      end
      ST_REQUEST: begin
        if (i_update_ui_time) begin
          w_state_nxt = ST_ACK;
          w_latch     = 1'b1;
        end else if (r_tcnt == TC_LAST) begin
          w_state_nxt = ST_DONE;
          w_timeout   = 1'b1;
        end
      end
      ST_ACK: begin
        if (!i_update_ui_time) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!i_pause && (w_time >= r_expiry)) begin
          if (r_ui_addr == i_end_addr) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_REQUEST;
            w_adv       = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, address/expiry latches and the handshake timeout counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ui_addr <= '0;
      r_expiry  <= '0;
      r_tcnt    <= '0;
      r_sync    <= 1'b1;
      r_apply   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_sync  <= (w_state_nxt != ST_REQUEST);
      r_busy  <= (w_state_nxt == ST_REQUEST) || (w_state_nxt == ST_ACK) ||
                 (w_state_nxt == ST_HOLD);
      r_done  <= (w_state_nxt == ST_DONE);
      r_apply <= w_latch;
      if (w_load)     r_ui_addr <= i_start_addr;
      else if (w_adv) r_ui_addr <= r_ui_addr + 1'b1;
      if (w_latch)    r_expiry <= i_next_ui_time;
      if (w_load)         r_error <= 1'b0;
      else if (w_timeout) r_error <= 1'b1;
      if ((r_state == ST_REQUEST) && (w_state_nxt == ST_REQUEST))
        r_tcnt <= r_tcnt + 1'b1;
      else
        r_tcnt <= '0;
    end
  end

  assign o_ui_addr      = r_ui_addr;
  assign o_sync_ui_time = r_sync;
  assign o_current_time = w_time;
  assign o_ui_apply     = r_apply;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule

// File: tb/tb_game_ui_sequencer.sv
// Bench for game_ui_sequencer: reader stand-in, behavioural model, directed and random runs.
module tb_game_ui_sequencer;
  localparam int AW = 10;
  localparam int TW = 30;
  localparam int TO = 64;
  localparam logic [TW-1:0] TMAX = '1;
  localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_HOLD = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst;
  logic st, pz, tk, upd;
  logic [AW-1:0] sa, ea;
  logic [TW-1:0] nut;
  logic [AW-1:0] ui_addr;
  logic sync, apply, busy, done, err;
  logic [TW-1:0] ctime;

  // small-width instance for the saturation scenario
  logic s_st, s_pz, s_tk, s_upd;
  logic [3:0] s_sa, s_ea, s_addr;
  logic [5:0] s_nut, s_time;
  logic s_sync, s_apply, s_busy, s_done, s_err;

  always #5 clk = ~clk;

  game_ui_sequencer #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(TW), .TIMEOUT_CYCLES(TO)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_start(st), .i_pause(pz), .i_time_tick(tk),
    .i_start_addr(sa), .i_end_addr(ea), .i_update_ui_time(upd), .i_next_ui_time(nut),
    .o_ui_addr(ui_addr), .o_sync_ui_time(sync), .o_current_time(ctime),
    .o_ui_apply(apply), .o_busy(busy), .o_done(done), .o_error(err));

  game_ui_sequencer #(.ADDR_WIDTH(4), .MAXIMUM_TIMES(6), .TIMEOUT_CYCLES(TO)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_start(s_st), .i_pause(s_pz), .i_time_tick(s_tk),
    .i_start_addr(s_sa), .i_end_addr(s_ea), .i_update_ui_time(s_upd), .i_next_ui_time(s_nut),
    .o_ui_addr(s_addr), .o_sync_ui_time(s_sync), .o_current_time(s_time),
    .o_ui_apply(s_apply), .o_busy(s_busy), .o_done(s_done), .o_error(s_err));

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int ph;
    logic [AW-1:0] addr;
    logic [TW-1:0] t, ex;
    int wt;
    bit sync, apply, busy, done, err;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t r;
    r.ph = P_IDLE; r.addr = '0; r.t = '0; r.ex = '0; r.wt = 0;
    r.sync = 1; r.apply = 0; r.busy = 0; r.done = 0; r.err = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t c, bit i_st, bit i_pz, bit i_tk, bit i_upd,
                                 logic [TW-1:0] i_nut, logic [AW-1:0] i_sa, logic [AW-1:0] i_ea);
    mdl_t n = c;
    n.apply = 0;
    if (c.busy && !i_pz && i_tk && c.t != TMAX) n.t = c.t + 1'b1;
    case (c.ph)
      P_IDLE, P_DONE:
        if (i_st) begin n.ph = P_REQ; n.addr = i_sa; n.t = '0; n.err = 0; n.wt = 0; end
      P_REQ:
        if (i_upd) begin n.ex = i_nut; n.apply = 1; n.ph = P_ACK; end
        else begin
          n.wt = c.wt + 1;
          if (n.wt >= TO) begin n.err = 1; n.ph = P_DONE; end
        end
      P_ACK:
        if (!i_upd) n.ph = P_HOLD;
      default:
        if (!i_pz && c.t >= c.ex) begin
          if (c.addr == i_ea) n.ph = P_DONE;
          else begin n.addr = AW'((int'(c.addr) + 1) % (1 << AW)); n.ph = P_REQ; n.wt = 0; end
        end
    endcase
    n.sync = (n.ph != P_REQ);
    n.busy = (n.ph == P_REQ) || (n.ph == P_ACK) || (n.ph == P_HOLD);
    n.done = (n.ph == P_DONE);
    return n;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) m <= mreset();
    else     m <= mstep(m, st, pz, tk, upd, nut, sa, ea);

  // Compare every output against the model once per cycle.
  always @(negedge clk)
    if (chk_en && !rst) begin
      chk("ui_addr", 64'(ui_addr), 64'(m.addr));
      chk("sync_ui_time", 64'(sync), 64'(m.sync));
      chk("current_time", 64'(ctime), 64'(m.t));
      chk("ui_apply", 64'(apply), 64'(m.apply));
      chk("busy", 64'(busy), 64'(m.busy));
      chk("done", 64'(done), 64'(m.done));
      chk("error", 64'(err), 64'(m.err));
    end

  // ---------------- reader stand-in and cycle driver ----------------
  bit rd_silent = 0, rd_rand = 0;
  int rd_dly = 0, rd_cnt = 0;
  logic [TW-1:0] dir_tab [4];
  logic [AW-1:0] q_ap [$];
  logic [TW-1:0] q_rq [$];
  logic prev_sync = 1'b1;
  int e [$];

  function automatic logic [TW-1:0] pick();
    int r;
    if (rd_rand) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) return (ctime >= 3) ? ctime - 3 : '0;
      return ctime + TW'($urandom_range(0, 10));
    end
    return dir_tab[ui_addr[1:0]];
  endfunction

  task automatic set_tab(input int a, input int b, input int c, input int d);
    dir_tab[0] = TW'(a); dir_tab[1] = TW'(b); dir_tab[2] = TW'(c); dir_tab[3] = TW'(d);
  endtask

  task automatic cycle();
    @(negedge clk);
    if (apply === 1'b1) q_ap.push_back(ui_addr);
    if (sync === 1'b0 && prev_sync === 1'b1) q_rq.push_back(ctime);
    prev_sync = sync;
    if (!upd) begin
      if (sync === 1'b0 && !rd_silent) begin
        if (rd_cnt >= rd_dly) begin upd = 1; nut = pick(); rd_cnt = 0; end
        else rd_cnt++;
      end else rd_cnt = 0;
    end else if (sync === 1'b1) begin
      if (rd_cnt >= rd_dly) begin upd = 0; rd_cnt = 0; end
      else rd_cnt++;
    end
  endtask

  task automatic pulse_start(input int a, input int b);
    sa = AW'(a); ea = AW'(b); st = 1;
    cycle();
    st = 0;
  endtask

  task automatic wait_done(input int bound, input string nm, output int n);
    n = 0;
    while (done !== 1'b1 && n < bound) begin cycle(); n++; end
    if (done !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL %s: done not seen within %0d cycles", nm, bound);
    end
  endtask

  task automatic chk_ap(input string nm);
    chk({nm, "_count"}, 64'(q_ap.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(nm, (i < q_ap.size()) ? 64'(q_ap[i]) : 64'hFFFF, 64'(e[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit wrapped;
    logic [5:0] s_prev;
    rst = 1; st = 0; pz = 0; tk = 1; upd = 0; sa = '0; ea = '0; nut = '0;
    s_st = 0; s_pz = 0; s_tk = 1; s_upd = 0; s_sa = 4'd0; s_ea = 4'd1; s_nut = '0;
    set_tab(0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_ui_addr", 64'(ui_addr), 64'd0);
    chk("rst_sync", 64'(sync), 64'd1);
    chk("rst_time", 64'(ctime), 64'd0);
    chk("rst_apply", 64'(apply), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(err), 64'd0);
    rst = 0;
    chk_en = 1;
    cycle();

    // scripted three-entry run, expiries 5, 8, 8
    set_tab(5, 8, 8, 8); rd_dly = 0;
    q_ap.delete(); q_rq.delete();
    pulse_start(0, 2);
    wait_done(100, "t1_wait", n);
    e = {0, 1, 2};
    chk_ap("t1_apply_addr");
    chk("t1_req_count", 64'(q_rq.size()), 64'd3);
    chk("t1_req_t1", (q_rq.size() > 1) ? 64'(q_rq[1]) : 64'hFFFF, 64'd6);
    chk("t1_req_t2", (q_rq.size() > 2) ? 64'(q_rq[2]) : 64'hFFFF, 64'd9);
    chk("t1_final_time", 64'(ctime), 64'd12);
    chk("t1_model_time", 64'(m.t), 64'd12);
    chk("t1_error", 64'(err), 64'd0);

    // silent reader: timeout 64 cycles after sync falls
    rd_silent = 1; q_ap.delete();
    pulse_start(7, 7);
    wait_done(200, "t2_wait", n);
    chk("t2_timeout_cycles", 64'(n), 64'd64);
    chk("t2_error", 64'(err), 64'd1);
    chk("t2_addr", 64'(ui_addr), 64'd7);
    chk("t2_no_apply", 64'(q_ap.size()), 64'd0);
    rd_silent = 0;

    // pause during HOLD with expiry 10
    set_tab(10, 10, 10, 10);
    pulse_start(5, 5);
    n = 0;
    while (ctime !== 30'd4 && n < 20) begin cycle(); n++; end
    chk("t3_reach4", 64'(ctime), 64'd4);
    pz = 1;
    repeat (20) cycle();
    chk("t3_frozen_time", 64'(ctime), 64'd4);
    chk("t3_still_busy", 64'(busy), 64'd1);
    chk("t3_not_done", 64'(done), 64'd0);
    pz = 0;
    wait_done(100, "t3_wait", n);
    chk("t3_done_time", 64'(ctime), 64'd11);
    chk("t3_model_time", 64'(m.t), 64'd11);

    // reset while in REQUEST
    chk_en = 0; rd_silent = 1;
    pulse_start(300, 301);
    chk("t4_pre_sync", 64'(sync), 64'd0);
    chk("t4_pre_addr", 64'(ui_addr), 64'd300);
    #1 rst = 1; upd = 0; rd_cnt = 0;
    #1;
    chk("t4_ui_addr", 64'(ui_addr), 64'd0);
    chk("t4_sync", 64'(sync), 64'd1);
    chk("t4_time", 64'(ctime), 64'd0);
    chk("t4_apply", 64'(apply), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_done", 64'(done), 64'd0);
    chk("t4_error", 64'(err), 64'd0);
    cycle();
    rst = 0;
    rd_silent = 0;
    repeat (3) begin cycle(); chk("t4_no_apply", 64'(apply), 64'd0); end
    chk_en = 1;

    // address wrap 1022 -> 1, immediate expiries
    set_tab(0, 0, 0, 0); q_ap.delete();
    pulse_start(1022, 1);
    wait_done(100, "t5_wait", n);
    e = {1022, 1023, 0, 1};
    chk_ap("t5_apply_addr");
    chk("t5_error", 64'(err), 64'd0);

    // randomized run against the model
    rd_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      tk = ($urandom_range(0, 9) < 7);
      pz = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 11) == 0);
      if (st) begin
        sa = AW'($urandom);
        ea = sa + AW'($urandom_range(0, 3));
        rd_silent = ($urandom_range(0, 9) == 0);
      end
      rd_dly = int'($urandom_range(0, 3));
      cycle();
    end
    st = 0; pz = 0; tk = 1; rd_silent = 0;

    // saturation on a 6-bit time counter, expiry all-ones
    s_nut = 6'h3F;
    s_st = 1; cycle(); s_st = 0;
    wrapped = 0; s_prev = '0; n = 0;
    while (s_done !== 1'b1 && n < 300) begin
      if (!s_upd && s_sync === 1'b0) s_upd = 1;
      else if (s_upd && s_sync === 1'b1) s_upd = 0;
      cycle(); n++;
      if (s_time < s_prev) wrapped = 1;
      s_prev = s_time;
    end
    chk("t6_done", 64'(s_done), 64'd1);
    chk("t6_time_sat", 64'(s_time), 64'd63);
    chk("t6_no_wrap", 64'(wrapped), 64'd0);
    chk("t6_end_addr", 64'(s_addr), 64'd1);
    chk("t6_error", 64'(s_err), 64'd0);
    repeat (3) cycle();
    chk("t6_time_held", 64'(s_time), 64'd63);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
